// File: rtl/seg7_digit_counter.sv
// seg7_digit_counter
// Single-digit BCD event counter driving a 7-segment display.
// The raw push-button is synchronized and debounced, and each accepted press
// steps the digit up or down. Clear and load commands take priority over a
// step. The digit is encoded to segments, and the decimal point flashes for a
// fixed number of cycles after every wrap-around.

module seg7_digit_counter #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BLINK_DIV       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_inc,
    input  logic       mode,
    input  logic       clr,
    input  logic       load_en,
    input  logic [3:0] load_val,
    output logic [3:0] digit,
    output logic [6:0] segments,
    output logic       dp,
    output logic       wrap
);

    // The debounce counter only has to reach DEBOUNCE_CYCLES-1, and it keeps at
    // least one bit so that DEBOUNCE_CYCLES = 1 still elaborates.
    localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // The hold counter must be able to represent BLINK_DIV itself.
    localparam int HCW = $clog2(BLINK_DIV + 1);

    localparam logic [DCW-1:0] DCNT_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HCW-1:0] HOLD_INIT = HCW'(BLINK_DIV);

    // BCD digit to active-high segment pattern (bit0 = a ... bit6 = g).
    // Codes above 9 cannot occur in the digit register; they blank the display.
    function automatic logic [6:0] seg7_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic           r_sync_meta;
    logic           r_sync;
    logic           r_db;
    logic           r_db_q;
    logic [DCW-1:0] r_dcnt;
    logic [3:0]     r_digit;
    logic [6:0]     r_seg;
    logic           r_wrap;
    logic           r_dp;
    logic [HCW-1:0] r_hold;

    logic           w_step;
    logic [3:0]     w_digit_nxt;
    logic           w_wrap_nxt;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
        end else begin
            r_sync_meta <= btn_inc;
            r_sync      <= r_sync_meta;
        end
    end

    // Accept a new button level only after DEBOUNCE_CYCLES consecutive
    // samples that disagree with the current debounced level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db   <= 1'b0;
            r_dcnt <= '0;
        end else if (r_sync == r_db) begin
            r_dcnt <= '0;
        end else if (r_dcnt == DCNT_LAST) begin
            r_db   <= r_sync;
            r_dcnt <= '0;
        end else begin
            r_dcnt <= r_dcnt + DCW'(1);
        end
    end

    // Delayed copy of the debounced level, used to detect the press edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_q <= 1'b0;
        end else begin
            r_db_q <= r_db;
        end
    end

    // Only the press edge steps the digit; a release is ignored.
    assign w_step = r_db & ~r_db_q;

    // Next digit in priority order: clear, load, step. A load of an illegal
    // value holds the digit and still swallows a coincident step.
    always_comb begin
        w_digit_nxt = r_digit;
        w_wrap_nxt  = 1'b0;
        if (clr) begin
            w_digit_nxt = 4'd0;
        end else if (load_en) begin
            if (load_val <= 4'd9) begin
                w_digit_nxt = load_val;
            end
        end else if (w_step) begin
            if (!mode) begin
                if (r_digit >= 4'd9) begin
                    w_digit_nxt = 4'd0;
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_digit_nxt = r_digit + 4'd1;
                end
            end else begin
                if (r_digit == 4'd0) begin
                    w_digit_nxt = 4'd9;
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_digit_nxt = r_digit - 4'd1;
                end
            end
        end
    end

    // Register the digit together with its segment pattern and the wrap pulse,
    // so all three change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digit <= 4'd0;
            r_seg   <= 7'h3F;
            r_wrap  <= 1'b0;
        end else begin
            r_digit <= w_digit_nxt;
            r_seg   <= seg7_encode(w_digit_nxt);
            r_wrap  <= w_wrap_nxt;
        end
    end

    // Decimal-point flash: each wrap (re)loads the hold counter, and the
    // registered dp is high while the counter is nonzero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
            r_dp   <= 1'b0;
        end else if (w_wrap_nxt) begin
            r_hold <= HOLD_INIT;
            r_dp   <= 1'b1;
        end else if (r_hold != '0) begin
            r_hold <= r_hold - HCW'(1);
            r_dp   <= (r_hold > HCW'(1));
        end else begin
            r_dp   <= 1'b0;
        end
    end

    assign digit    = r_digit;
    assign segments = r_seg;
    assign wrap     = r_wrap;
    assign dp       = r_dp;

endmodule

// File: tb/tb_seg7_digit_counter.sv
// Scoreboard testbench for seg7_digit_counter.
// The driver applies one input vector per cycle. For each vector, a
// behavioural model predicts the outputs after the next rising edge and
// pushes them into a queue. The monitor pops one expectation per edge and
// compares it with the DUT.

module tb_seg7_digit_counter;

    localparam int D  = 4;
    localparam int BL = 8;

    typedef struct {
        logic [3:0] digit;
        logic [6:0] seg;
        logic       dp;
        logic       wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_inc = 1'b0;
    logic       mode = 1'b0;
    logic       clr = 1'b0;
    logic       load_en = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] digit;
    logic [6:0] segments;
    logic       dp;
    logic       wrap;

    seg7_digit_counter #(.DEBOUNCE_CYCLES(D), .BLINK_DIV(BL)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_inc  (btn_inc),
        .mode     (mode),
        .clr      (clr),
        .load_en  (load_en),
        .load_val (load_val),
        .digit    (digit),
        .segments (segments),
        .dp       (dp),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    // Segment patterns for digits 0-9.
    logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    bit   running    = 0;

    // Reference model state.
    int   n_edge    = 0;
    int   digit_m   = 0;
    int   last_wrap = -1000000;
    bit   sync_a = 0, sync_b = 0;
    bit   db_m = 0, rose_m = 0;
    bit   hist[$];

    // Predict the state after one rising edge, given the inputs sampled there.
    task automatic model_edge(input bit b, input bit m, input bit c, input bit le,
                              input int lv, input bit r);
        exp_t e;
        bit   wr;
        bit   samp;
        bit   all_diff;
        n_edge++;
        wr = 0;
        if (r) begin
            digit_m   = 0;
            sync_a    = 0;
            sync_b    = 0;
            db_m      = 0;
            rose_m    = 0;
            hist.delete();
            last_wrap = -1000000;
        end else begin
            // The digit reacts to a press edge of the debounced level seen
            // one edge earlier.
            if (c) begin
                digit_m = 0;
            end else if (le) begin
                if (lv < 10) digit_m = lv;
            end else if (rose_m) begin
                if (!m) begin
                    wr      = (digit_m == 9);
                    digit_m = (digit_m + 1) % 10;
                end else begin
                    wr      = (digit_m == 0);
                    digit_m = (digit_m + 9) % 10;
                end
            end
            if (wr) last_wrap = n_edge;
            // The debounced level flips once the last D synchronized samples
            // all disagree with it.
            samp   = sync_b;
            sync_b = sync_a;
            sync_a = b;
            hist.push_back(samp);
            if (hist.size() > D) void'(hist.pop_front());
            rose_m = 0;
            if (hist.size() == D) begin
                all_diff = 1;
                foreach (hist[i]) if (hist[i] == db_m) all_diff = 0;
                if (all_diff) begin
                    db_m   = ~db_m;
                    rose_m = db_m;
                end
            end
        end
        e.digit = 4'(digit_m);
        e.seg   = SEG[digit_m];
        e.wrap  = wr;
        e.dp    = ((n_edge - last_wrap) < BL);
        exp_q.push_back(e);
    endtask

    // Apply one vector mid-cycle and record its expected outcome.
    task automatic cyc(input bit b, input bit m, input bit c, input bit le,
                       input int lv, input bit r);
        @(negedge clk);
        btn_inc  = b;
        mode     = m;
        clr      = c;
        load_en  = le;
        load_val = 4'(lv);
        rst      = r;
        running  = 1;
        model_edge(b, m, c, le, lv, r);
    endtask

    // Monitor: one expectation is consumed per rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (running) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL vec%0d: scoreboard empty, DUT digit=%0d", vectors, digit);
            end else begin
                e = exp_q.pop_front();
                if (digit !== e.digit || segments !== e.seg || dp !== e.dp || wrap !== e.wrap) begin
                    miscompares++;
                    $display("FAIL vec%0d t=%0t: got digit=%0d seg=%02h dp=%0b wrap=%0b, expected digit=%0d seg=%02h dp=%0b wrap=%0b",
                             vectors, $time, digit, segments, dp, wrap, e.digit, e.seg, e.dp, e.wrap);
                end
            end
        end
    end

    initial begin
        int run_left;
        bit b;
        // Reset, then idle.
        repeat (2)  cyc(0, 0, 0, 0, 0, 1);
        repeat (20) cyc(0, 0, 0, 0, 0, 0);
        // 10-cycle press counting up, then a 3-cycle glitch.
        repeat (10) cyc(1, 0, 0, 0, 0, 0);
        repeat (12) cyc(0, 0, 0, 0, 0, 0);
        repeat (3)  cyc(1, 0, 0, 0, 0, 0);
        repeat (12) cyc(0, 0, 0, 0, 0, 0);
        // Load 9 and count up through the wrap, watching the dp flash.
        cyc(0, 0, 0, 1, 9, 0);
        repeat (2)  cyc(0, 0, 0, 0, 0, 0);
        repeat (10) cyc(1, 0, 0, 0, 0, 0);
        repeat (14) cyc(0, 0, 0, 0, 0, 0);
        // Count down from 0 to 9.
        repeat (10) cyc(1, 1, 0, 0, 0, 0);
        repeat (14) cyc(0, 1, 0, 0, 0, 0);
        // Illegal load is ignored.
        cyc(0, 0, 0, 1, 5, 0);
        cyc(0, 0, 0, 1, 12, 0);
        repeat (3)  cyc(0, 0, 0, 0, 0, 0);
        // Clear on the step edge, with the digit at 9 so the step would wrap.
        cyc(0, 0, 0, 1, 9, 0);
        repeat (6)  cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        repeat (4)  cyc(1, 0, 0, 0, 0, 0);
        repeat (12) cyc(0, 0, 0, 0, 0, 0);
        // Reset while dp flashes and the button is held.
        cyc(0, 0, 0, 1, 9, 0);
        repeat (9)  cyc(1, 0, 0, 0, 0, 0);
        repeat (2)  cyc(1, 0, 0, 0, 0, 1);
        repeat (14) cyc(1, 0, 0, 0, 0, 0);
        repeat (12) cyc(0, 0, 0, 0, 0, 0);
        // Randomized traffic: button runs of random length, including
        // glitches, plus occasional clear, load and reset.
        run_left = 0;
        b = 0;
        for (int i = 0; i < 4000; i++) begin
            if (run_left == 0) begin
                b = ~b;
                run_left = $urandom_range(1, 14);
            end
            run_left--;
            cyc(b, bit'($urandom_range(0, 1)),
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 29) == 0),
                int'($urandom_range(0, 15)),
                ($urandom_range(0, 499) == 0));
        end
        @(posedge clk);
        #2;
        running = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_digit_counter.md
# seg7_digit_counter

Single-digit BCD event counter feeding the 7-segment outputs of the top-level user module (`uo_out[6:0]` segments, `uo_out[7]` decimal point). It debounces a raw push-button from `ui_in`, steps a 0–9 digit up or down, and accepts clear and load commands from the core logic. It encodes the digit to segments and flashes the decimal point on wrap-around. It is the last stage before the output pins.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples needed to accept a new button level (≥1).
- `BLINK_DIV`, default 8: number of cycles `dp` stays high after a wrap (≥1).

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous reset, active-high. The top level drives it as `~rst_n`.
- `btn_inc`  in  1  raw asynchronous push-button, active-high. A press steps the digit.
- `mode`  in  1  step direction: 0 = up, 1 = down. Synchronous, sampled on the step cycle.
- `clr`  in  1  synchronous clear to 0.
- `load_en`  in  1  synchronous load of `load_val`.
- `load_val`  in  4  value to load; only 0–9 are legal.
- `digit`  out  4  current BCD value.
- `segments`  out  7  active-high segments, bit0 = a … bit6 = g.
- `dp`  out  1  decimal point, high during the wrap flash.
- `wrap`  out  1  one-cycle pulse on 9→0 (up) or 0→9 (down).

## Operation
- Input path: `btn_inc` passes through a 2-flop synchronizer whose output is `s`.
- Debounce: the debounced level `db` and a counter `dcnt` are tracked per cycle.
  - If `s == db`: `dcnt <= 0`.
  - Otherwise, when `dcnt == DEBOUNCE_CYCLES-1`: `db <= s` and `dcnt <= 0`. Before that: `dcnt <= dcnt+1`.
  - Glitches shorter than `DEBOUNCE_CYCLES` cycles are fully rejected.
- Step: `step = db & ~db_q`, where `db_q` is `db` delayed one cycle. Only a rising edge counts; releases never count.
- Digit update, in priority order each cycle:
  - `clr`: digit ← 0.
  - Else `load_en` with `load_val` ≤ 9: digit ← `load_val`. When `load_val` > 9, the load is ignored and the digit holds.
  - Else `step` with `mode` = 0: digit ← digit+1, and 9 → 0 with `wrap` = 1.
  - Else `step` with `mode` = 1: digit ← digit−1, and 0 → 9 with `wrap` = 1.
  - Otherwise the digit holds.
  - A step coinciding with `clr` or `load_en` (legal or ignored) is dropped and does not produce `wrap`.
- Segment decode, registered, updated on the same edge as `digit`:
  - 0 = 0x3F, 1 = 0x06, 2 = 0x5B, 3 = 0x4F, 4 = 0x66
  - 5 = 0x6D, 6 = 0x7D, 7 = 0x07, 8 = 0x7F, 9 = 0x6F
- DP flash:
  - On a `wrap` edge, the hold counter is set to `BLINK_DIV`, and `dp` is high while the counter is nonzero. The counter decrements every cycle.
  - A new wrap during the flash reloads the counter to `BLINK_DIV`, extending the flash.
  - `clr` does not cancel a flash in progress.
- `digit` never holds a value above 9.

## Timing
- Reset (`rst` high at an edge): `digit` = 0, `segments` = 0x3F, `dp` = 0, `wrap` = 0. Synchronizer, `db`, `db_q`, `dcnt` and the hold counter are all 0.
- Reset mid-operation: all state is discarded, including any partial debounce or flash. If the button is still held when `rst` is released, `db` rises after debounce, so one step is counted.
- Button latency: `btn_inc` rises before edge k.
  - `s` = 1 after edge k+1.
  - `db` = 1 after edge k+1+`DEBOUNCE_CYCLES`.
  - `digit`, `segments` and `wrap` update at edge k+2+`DEBOUNCE_CYCLES`. With default parameters this is 6 edges.
- `dp` rises on the same edge as the `wrap` pulse, and stays high for exactly `BLINK_DIV` cycles.
- `clr` and `load` take effect on the edge at which they are sampled high, with 1-cycle latency.
- Maximum step rate: one step per `2·DEBOUNCE_CYCLES` cycles, because a press and a release are each debounced.

## Test plan
- Reset, then idle 20 cycles: `digit` = 0, `segments` = 0x3F, `dp` = 0 and `wrap` = 0 throughout.
- Hold `btn_inc` 10 cycles then release, with `mode` = 0: `digit` becomes 1 exactly 6 edges after the press and stays 1 after release. A 3-cycle pulse on `btn_inc` gives no change.
- `load_val` = 9 with `load_en`, then one press with `mode` = 0:
  - `digit` = 0 and `segments` = 0x3F.
  - `wrap` is a 1-cycle pulse.
  - `dp` is high for exactly 8 cycles.
- With `digit` = 0 and `mode` = 1, one press: `digit` = 9, `segments` = 0x6F and `wrap` pulses.
- `load_val` = 12 with `load_en` at `digit` = 5: digit stays 5. Asserting `clr` on the same edge as a step leaves `digit` = 0 with no `wrap`.
- Assert `rst` while `dp` is flashing and the button is held:
  - `dp` = 0 immediately and `digit` = 0.
  - After release of `rst` with the button still held, exactly one step to 1 occurs.
